// File: rtl/wdata_burst_sender_if.sv
// Signal bundle between the write-data burst sender, the write-data FIFO,
// the command path and the DQ pads.
interface wdata_burst_sender_if #(
  parameter int DQ_W    = 16,
  parameter int WDATA_W = 64
);
  logic               wr_cmd;
  logic [WDATA_W-1:0] fifo_data;
  logic               fifo_empty;
  logic               fifo_ren;
  logic [DQ_W-1:0]    dq_out;
  logic               dq_oe;
  logic               dqs_oe;
  logic               busy;
  logic               underflow_err;
  logic               collision_err;
  logic               err_clr;

  modport master (
    input  wr_cmd, fifo_data, fifo_empty, err_clr,
    output fifo_ren, dq_out, dq_oe, dqs_oe, busy, underflow_err, collision_err
  );

  modport slave (
    output wr_cmd, fifo_data, fifo_empty, err_clr,
    input  fifo_ren, dq_out, dq_oe, dqs_oe, busy, underflow_err, collision_err
  );
endinterface

// File: rtl/wdata_burst_sender.sv
// Write-latency delay line plus burst serialiser from the write-data FIFO onto DQ.
// Optional feature: define WDATA_PREAMBLE_EN for a one-cycle DQS preamble (needs WL >= 2).
module wdata_burst_sender #(
  parameter int DQ_W    = 16,
  parameter int BEATS   = 4,
  parameter int WDATA_W = DQ_W * BEATS,
  parameter int WL      = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  wdata_burst_sender_if.master bus
);

  localparam int            BW   = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t             state, state_nxt;
  logic [WL-1:0]      lat_pipe, lat_nxt;
  logic [BW-1:0]      beat_cnt, beat_nxt;
  logic [WDATA_W-1:0] sreg, sreg_nxt;
  logic [DQ_W-1:0]    dq_q, dq_nxt;
  logic               dq_oe_q, dq_oe_nxt;
  logic               dqs_oe_q, dqs_oe_nxt;
  logic               busy_q, busy_nxt;
  logic               und_q, und_nxt;
  logic               col_q, col_nxt;
  logic               start, last_beat, collide, accept;

  generate
    if (WL == 1) begin : g_lat_single
      assign lat_nxt = bus.wr_cmd;
    end else begin : g_lat_multi
      assign lat_nxt = {lat_pipe[WL-2:0], bus.wr_cmd};
    end
  endgenerate

`ifdef WDATA_PREAMBLE_EN
  logic pre_src;
  generate
    if (WL >= 2) begin : g_pre
      assign pre_src = lat_pipe[WL-2];
    end else begin : g_no_pre
      assign pre_src = 1'b0;
    end
  endgenerate
`endif

  // A start landing mid-burst is dropped; on the final beat it chains seamlessly.
  assign start     = lat_pipe[WL-1];
  assign last_beat = (beat_cnt == LAST);
  assign collide   = start && (state == SEND) && !last_beat;
  assign accept    = start && !collide;

  assign bus.fifo_ren      = accept && !bus.fifo_empty && rst_n;
  assign bus.dq_out        = dq_q;
  assign bus.dq_oe         = dq_oe_q;
  assign bus.dqs_oe        = dqs_oe_q;
  assign bus.busy          = busy_q;
  assign bus.underflow_err = und_q;
  assign bus.collision_err = col_q;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    sreg_nxt  = sreg;
    dq_nxt    = '0;
    dq_oe_nxt = 1'b0;
    und_nxt   = bus.err_clr ? 1'b0 : und_q;
    col_nxt   = bus.err_clr ? 1'b0 : col_q;

    if (accept) begin
      state_nxt = SEND;
      beat_nxt  = '0;
      sreg_nxt  = bus.fifo_empty ? '0 : bus.fifo_data;
      dq_nxt    = sreg_nxt[DQ_W-1:0];
      dq_oe_nxt = 1'b1;
      if (bus.fifo_empty) begin
        und_nxt = 1'b1;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = IDLE;
        end
        SEND: begin
          if (last_beat) begin
            state_nxt = IDLE;
          end else begin
            beat_nxt  = beat_cnt + BW'(1);
            sreg_nxt  = sreg >> DQ_W;
            dq_nxt    = sreg_nxt[DQ_W-1:0];
            dq_oe_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (collide) begin
      col_nxt = 1'b1;
    end

    busy_nxt = (state_nxt == SEND) || (|lat_nxt);

`ifdef WDATA_PREAMBLE_EN
    dqs_oe_nxt = dq_oe_nxt || pre_src;
`else
    dqs_oe_nxt = dq_oe_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_pipe <= '0;
      beat_cnt <= '0;
      sreg     <= '0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      dqs_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      und_q    <= 1'b0;
      col_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_pipe <= lat_nxt;
      beat_cnt <= beat_nxt;
      sreg     <= sreg_nxt;
      dq_q     <= dq_nxt;
      dq_oe_q  <= dq_oe_nxt;
      dqs_oe_q <= dqs_oe_nxt;
      busy_q   <= busy_nxt;
      und_q    <= und_nxt;
      col_q    <= col_nxt;
    end
  end

endmodule

// File: tb/tb_wdata_burst_sender.sv
// Directed and randomized bench for wdata_burst_sender against a timeline model
// that tracks command edges, burst windows and a FIFO queue.
module tb_wdata_burst_sender;

  localparam int DQ_W    = 16;
  localparam int BEATS   = 4;
  localparam int WDATA_W = DQ_W * BEATS;
  localparam int WL      = 5;
  localparam int MAXC    = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  wdata_burst_sender_if #(.DQ_W(DQ_W), .WDATA_W(WDATA_W)) bus ();

  wdata_burst_sender #(
    .DQ_W   (DQ_W),
    .BEATS  (BEATS),
    .WDATA_W(WDATA_W),
    .WL     (WL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  int                 tests      = 0;
  int                 fails      = 0;
  int                 edge_n     = 0;
  int                 hist_floor = 0;
  int                 last_start = -1000;
  bit                 cmd_at[MAXC];
  logic [WDATA_W-1:0] fifo_q[$];
  logic [WDATA_W-1:0] burst_data = '0;
  bit                 exp_und    = 1'b0;
  bit                 exp_col    = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s at edge %0d: got %h expected %h", tag, edge_n, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, check the pop strobe, then
  // advance the model across the rising edge and check registered outputs.
  task automatic applyStimulus(input bit cmd, input bit clr, input bit rstn);
    int                 n;
    bit                 start_now, accept, collide, empty, active, anycmd, pre;
    logic [DQ_W-1:0]    exp_dq;
    @(negedge clk);
    n     = edge_n + 1;
    empty = (fifo_q.size() == 0);
    bus.wr_cmd     = cmd;
    bus.err_clr    = clr;
    rst_n          = rstn;
    bus.fifo_empty = empty;
    bus.fifo_data  = empty ? {$urandom, $urandom} : fifo_q[0];
    start_now = 1'b0;
    if (n - WL > hist_floor) start_now = cmd_at[n-WL];
    accept  = start_now && (n >= last_start + BEATS);
    collide = start_now && !accept;
    #1;
    checkOutput("fifo_ren", 64'(bus.fifo_ren), 64'(accept && !empty && rstn));

    @(posedge clk);
    edge_n = n;
    if (!rstn) begin
      hist_floor = n;
      cmd_at[n]  = 1'b0;
      last_start = -1000;
      exp_und    = 1'b0;
      exp_col    = 1'b0;
    end else begin
      cmd_at[n] = cmd;
      if (accept) begin
        last_start = n;
        if (empty) burst_data = '0;
        else burst_data = fifo_q.pop_front();
      end
      if (accept && empty) exp_und = 1'b1;
      else if (clr) exp_und = 1'b0;
      if (collide) exp_col = 1'b1;
      else if (clr) exp_col = 1'b0;
    end
    #1;

    active = (n >= last_start) && (n < last_start + BEATS);
    exp_dq = '0;
    if (active) exp_dq = burst_data[(n-last_start)*DQ_W +: DQ_W];
    anycmd = 1'b0;
    for (int k = n - WL + 1; k <= n; k++) begin
      if (k > hist_floor) begin
        if (cmd_at[k]) anycmd = 1'b1;
      end
    end
    pre = 1'b0;
`ifdef WDATA_PREAMBLE_EN
    if (n - WL + 1 > hist_floor) pre = cmd_at[n-WL+1];
`endif
    checkOutput("dq_out", 64'(bus.dq_out), 64'(exp_dq));
    checkOutput("dq_oe", 64'(bus.dq_oe), 64'(active));
    checkOutput("dqs_oe", 64'(bus.dqs_oe), 64'(active || pre));
    checkOutput("busy", 64'(bus.busy), 64'(active || anycmd));
    checkOutput("underflow_err", 64'(bus.underflow_err), 64'(exp_und));
    checkOutput("collision_err", 64'(bus.collision_err), 64'(exp_col));
  endtask

  initial begin
    bus.wr_cmd     = 1'b0;
    bus.err_clr    = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;

    // Reset
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);

    // Single write with a known head entry
    fifo_q.push_back(64'h4444_3333_2222_1111);
    applyStimulus(1, 0, 1);
    repeat (12) applyStimulus(0, 0, 1);

    // Two commands BEATS apart: seamless bursts
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    applyStimulus(1, 0, 1);
    repeat (BEATS - 1) applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    repeat (14) applyStimulus(0, 0, 1);

    // Two commands 2 apart: collision, second entry stays queued
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    repeat (14) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 0, 1);

    // Underflow with empty FIFO, then clear
    fifo_q.delete();
    applyStimulus(1, 0, 1);
    repeat (10) applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 1);
    repeat (3) applyStimulus(0, 0, 1);

    // Reset at E6 during a burst with a second command in flight
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    applyStimulus(1, 0, 1);
    repeat (3) applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    repeat (15) applyStimulus(0, 0, 1);

    // Randomized traffic with refills, clears and occasional resets
    fifo_q.delete();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 6) fifo_q.push_back({$urandom, $urandom});
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 99) != 0);
    end
    repeat (12) applyStimulus(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
